// File: rtl/mult_div_ctrl.sv
// Mult/div sequencer: latches operands, pulses the selected unit, stalls the pipe and writes HI/LO.
// Optional WAIT-state abort is compiled in with `define MULT_DIV_TIMEOUT_EN.
module mult_div_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64,
  parameter int CNT_WIDTH  = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  input  logic [1:0]                req_op,
  input  logic [DATA_WIDTH-1:0]     operand_1,
  input  logic [DATA_WIDTH-1:0]     operand_2,
  input  logic                      flush,
  output logic                      mul_start,
  output logic                      div_start,
  output logic                      md_signed,
  output logic [DATA_WIDTH-1:0]     md_op_a,
  output logic [DATA_WIDTH-1:0]     md_op_b,
  input  logic                      mul_done,
  input  logic [2*DATA_WIDTH-1:0]   mul_result,
  input  logic                      div_done,
  input  logic [2*DATA_WIDTH-1:0]   div_result,
  output logic                      stall_request,
  output logic                      hilo_write_en,
  output logic [DATA_WIDTH-1:0]     hi_write_data,
  output logic [DATA_WIDTH-1:0]     lo_write_data,
  output logic                      busy,
  output logic                      timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                    state;
  logic                      sel_div;
  logic                      drain_done;
  logic                      sel_done;
  logic [2*DATA_WIDTH-1:0]   sel_result;
  logic                      div_by_zero;

  if (2**CNT_WIDTH <= TIMEOUT) begin : g_cnt_width_check
    $error("mult_div_ctrl: CNT_WIDTH too narrow for TIMEOUT");
  end

`ifdef MULT_DIV_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] wait_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  // Only the unit that was started may complete the operation.
  assign sel_done    = sel_div ? div_done   : mul_done;
  assign sel_result  = sel_div ? div_result : mul_result;
  assign div_by_zero = req_op[1] && (operand_2 == '0);

  assign busy          = (state != S_IDLE);
  assign stall_request = (state == S_IDLE && req_valid && !flush) ||
                         (state == S_WAIT) || (state == S_DRAIN);

  // NOTE: every register below uses <= so all of them update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      sel_div       <= 1'b0;
      drain_done    <= 1'b0;
      mul_start     <= 1'b0;
      div_start     <= 1'b0;
      md_signed     <= 1'b0;
      md_op_a       <= '0;
      md_op_b       <= '0;
      hilo_write_en <= 1'b0;
      hi_write_data <= '0;
      lo_write_data <= '0;
`ifdef MULT_DIV_TIMEOUT_EN
      wait_cnt      <= '0;
      timeout_err   <= 1'b0;
`endif
    end else begin
      mul_start     <= 1'b0;
      div_start     <= 1'b0;
      hilo_write_en <= 1'b0;

      case (state)
        S_IDLE: begin
          if (req_valid && !flush) begin
            if (div_by_zero) begin
              state         <= S_DONE;
              hilo_write_en <= 1'b1;
              hi_write_data <= operand_1;
              lo_write_data <= '1;
            end else begin
              state     <= S_WAIT;
              md_op_a   <= operand_1;
              md_op_b   <= operand_2;
              md_signed <= ~req_op[0];
              sel_div   <= req_op[1];
              mul_start <= ~req_op[1];
              div_start <= req_op[1];
`ifdef MULT_DIV_TIMEOUT_EN
              wait_cnt  <= '0;
`endif
            end
          end
        end

        S_WAIT: begin
          if (flush) begin
            // A result landing with the flush is dropped but still ends the drain.
            state      <= S_DRAIN;
            drain_done <= sel_done;
          end else if (sel_done) begin
            state         <= S_DONE;
            hilo_write_en <= 1'b1;
            hi_write_data <= sel_result[2*DATA_WIDTH-1:DATA_WIDTH];
            lo_write_data <= sel_result[DATA_WIDTH-1:0];
          end
`ifdef MULT_DIV_TIMEOUT_EN
          else if (wait_cnt == CNT_WIDTH'(TIMEOUT - 1)) begin
            state       <= S_IDLE;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        S_DRAIN: begin
          if (drain_done || sel_done) begin
            state      <= S_IDLE;
            drain_done <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Randomised self-checking bench for mult_div_ctrl; the bench plays both arithmetic units and
// predicts HI/LO from plain arithmetic. Define MULT_DIV_TIMEOUT_EN to also exercise the abort.
module tb_mult_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] operand_1, operand_2;
  logic        flush;
  logic        mul_start, div_start, md_signed;
  logic [31:0] md_op_a, md_op_b;
  logic        mul_done, div_done;
  logic [63:0] mul_result, div_result;
  logic        stall_request, hilo_write_en, busy, timeout_err;
  logic [31:0] hi_write_data, lo_write_data;

  int          checks = 0;
  int          errors = 0;
  int          writes_seen = 0;
  int          writes_exp = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  mult_div_ctrl #(.DATA_WIDTH(32), .TIMEOUT(64), .CNT_WIDTH(7)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .operand_1(operand_1), .operand_2(operand_2), .flush(flush),
    .mul_start(mul_start), .div_start(div_start), .md_signed(md_signed),
    .md_op_a(md_op_a), .md_op_b(md_op_b),
    .mul_done(mul_done), .mul_result(mul_result),
    .div_done(div_done), .div_result(div_result),
    .stall_request(stall_request), .hilo_write_en(hilo_write_en),
    .hi_write_data(hi_write_data), .lo_write_data(lo_write_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  always @(negedge clk) if (hilo_write_en === 1'b1) writes_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // {HI,LO} the real arithmetic would produce: product, or {remainder, quotient}.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    logic [63:0] ua = {32'b0, a};
    logic [63:0] ub = {32'b0, b};
    longint      q, r;
    case (op)
      2'b00:   return 64'(sa * sb);
      2'b01:   return ua * ub;
      2'b10: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return {a % b, a / b};
    endcase
  endfunction

  task automatic drive_idle();
    req_valid = 1'b0; req_op = 2'b00; operand_1 = '0; operand_2 = '0; flush = 1'b0;
    mul_done = 1'b0; div_done = 1'b0; mul_result = '0; div_result = '0;
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    drive_idle();
    #1;
    check({tag, "_busy"}, busy, 0);
    check({tag, "_stall"}, stall_request, 0);
    check({tag, "_write"}, hilo_write_en, 0);
    check({tag, "_start"}, {mul_start, div_start}, 0);
    check({tag, "_hi_hold"}, hi_write_data, exp_hi);
    check({tag, "_lo_hold"}, lo_write_data, exp_lo);
    check({tag, "_tmo"}, timeout_err, 0);
  endtask

  // One request: k = cycle (after the request cycle) in which the unit reports done,
  // f = cycle in which flush is raised (0 = never), gap = insert an idle cycle afterwards.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int k, input int f, input bit gap);
    bit          is_div = op[1];
    bit          dz     = op[1] && (b == 0);
    logic [63:0] res    = '0;
    int          last;
    if (!dz) res = ref_result(op, a, b);

    @(negedge clk);
    req_valid = 1'b1; req_op = op; operand_1 = a; operand_2 = b; flush = 1'b0;
    mul_done = 1'b0; div_done = 1'b0;
    #1;
    check("req_stall", stall_request, 1);
    check("req_busy", busy, 0);
    check("req_write", hilo_write_en, 0);

    if (dz) begin
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1)); operand_2 = $urandom;
      #1;
      check("dz_write", hilo_write_en, 1);
      check("dz_hi", hi_write_data, a);
      check("dz_lo", lo_write_data, 32'hFFFF_FFFF);
      check("dz_stall", stall_request, 0);
      check("dz_start", {mul_start, div_start}, 0);
      exp_hi = a; exp_lo = 32'hFFFF_FFFF; writes_exp++;
    end else begin
      last = (f == 0) ? k : ((f + 1 > k) ? f + 1 : k);
      for (int c = 1; c <= last; c++) begin
        @(negedge clk);
        req_valid = 1'($urandom_range(0, 1)); req_op = 2'($urandom);
        operand_1 = $urandom; operand_2 = $urandom;
        flush = (c == f);
        if (is_div) begin
          div_done = (c == k); div_result = res;
          mul_done = ($urandom_range(0, 3) == 0); mul_result = {$urandom, $urandom};
        end else begin
          mul_done = (c == k); mul_result = res;
          div_done = ($urandom_range(0, 3) == 0); div_result = {$urandom, $urandom};
        end
        #1;
        check($sformatf("c%0d_busy", c), busy, 1);
        check($sformatf("c%0d_stall", c), stall_request, 1);
        check($sformatf("c%0d_write", c), hilo_write_en, 0);
        check($sformatf("c%0d_mul_start", c), mul_start, (c == 1) && !is_div);
        check($sformatf("c%0d_div_start", c), div_start, (c == 1) && is_div);
        if (c == 1) begin
          check("op_a", md_op_a, a);
          check("op_b", md_op_b, b);
          check("signed", md_signed, !op[0]);
        end
      end
      @(negedge clk);
      flush = 1'b0; mul_done = 1'b0; div_done = 1'b0;
      if (f == 0) begin
        req_valid = 1'($urandom_range(0, 1));
        #1;
        check("done_write", hilo_write_en, 1);
        check("done_hi", hi_write_data, res[63:32]);
        check("done_lo", lo_write_data, res[31:0]);
        check("done_stall", stall_request, 0);
        check("done_busy", busy, 1);
        exp_hi = res[63:32]; exp_lo = res[31:0]; writes_exp++;
      end else begin
        req_valid = 1'b0;
        #1;
        check("drain_exit_busy", busy, 0);
        check("drain_exit_stall", stall_request, 0);
        check("drain_exit_write", hilo_write_en, 0);
        check("drain_exit_hi", hi_write_data, exp_hi);
        check("drain_exit_lo", lo_write_data, exp_lo);
      end
    end
    if (gap) idle_check("post");
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          k, f;

    drive_idle();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_stall", stall_request, 0);
    check("rst_outs", {mul_start, div_start, md_signed, hilo_write_en, timeout_err}, 0);
    check("rst_ops", {md_op_a, md_op_b}, 0);
    check("rst_hilo", {hi_write_data, lo_write_data}, 0);
    @(negedge clk);
    rst = 1'b1;

    do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 4, 0, 1'b1);     // MULT -3 x 5
    do_op(2'b11, 32'd100, 32'd7, 3, 0, 1'b1);           // DIVU 100 / 7
    do_op(2'b10, 32'd5, 32'd0, 1, 0, 1'b1);             // DIV by zero
    do_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5, 2, 1'b1);  // MULTU flushed
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 2, 0, 1'b0);  // back-to-back MULT ...
    do_op(2'b10, 32'hFFFF_FF9C, 32'd7, 1, 0, 1'b1);          // ... then DIV -100 / 7
    do_op(2'b11, 32'd9, 32'd4, 2, 2, 1'b1);             // flush and done together

    // Flush beside a new request in IDLE, plus stray dones: nothing may start or write.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; flush = 1'b1; mul_done = 1'b1; div_done = 1'b1;
    #1;
    check("idle_flush_stall", stall_request, 0);
    idle_check("idle_flush");

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = (op[1] && $urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      k  = $urandom_range(1, 6);
      f  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, k) : 0;
      do_op(op, a, b, k, f, 1'($urandom_range(0, 1)));
    end
    idle_check("rand_end");

    // Asynchronous reset in the middle of WAIT, then a stray done in IDLE.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; operand_1 = 32'd3; operand_2 = 32'd4;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("mid_start", mul_start, 1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_stall", stall_request, 0);
    check("mid_rst_outs", {mul_start, md_signed, md_op_a, hi_write_data, lo_write_data}, 0);
    exp_hi = '0; exp_lo = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mul_done = 1'b1; mul_result = 64'hDEAD_BEEF_0000_0001;
    idle_check("stray_done");

`ifdef MULT_DIV_TIMEOUT_EN
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; operand_1 = 32'd6; operand_2 = 32'd7;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      if (c == 1 || c == 64) begin
        check($sformatf("tmo_c%0d_busy", c), busy, 1);
        check($sformatf("tmo_c%0d_err", c), timeout_err, 0);
      end
    end
    @(negedge clk);
    #1;
    check("tmo_busy", busy, 0);
    check("tmo_stall", stall_request, 0);
    check("tmo_err", timeout_err, 1);
    check("tmo_write", hilo_write_en, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("tmo_rst_err", timeout_err, 0);
    @(negedge clk);
    rst = 1'b1;
`endif

    @(negedge clk);
    drive_idle();
    check("write_count", 64'(writes_seen), 64'(writes_exp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
